// File: rtl/subtractor_pkg.sv
// subtractor_pkg
// Shared definitions for the multi-cycle subtractor:
//   - state_t         : FSM state encoding (IDLE, CALC, DONE)
//   - DEF_WIDTH       : default operand/result width
//   - DEF_DIGIT       : default bits processed per CALC cycle
//   - calc_overflow() : signed-overflow flag for a - b from operand and result signs
package subtractor_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtraction overflows only when the operands have different signs and
  // the result sign disagrees with the minuend.
  function automatic logic calc_overflow(input logic a_msb,
                                         input logic b_msb,
                                         input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/subtractor_digit.sv
// subtractor_digit
// Combinational DIGIT-bit ripple-borrow subtract slice: d_d = a_d - b_d - borrow_i.
// Ports:
//   a_d      in   DIGIT  minuend digit
//   b_d      in   DIGIT  subtrahend digit
//   borrow_i in   1      borrow into the least significant bit
//   d_d      out  DIGIT  difference digit
//   borrow_o out  1      borrow out of the most significant bit
module subtractor_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             borrow_i,
  output logic [DIGIT-1:0] d_d,
  output logic             borrow_o
);

  logic brw;

  // Full-subtractor chain; brw carries the borrow from bit i into bit i+1.
  always_comb begin
    d_d = '0;
    brw = borrow_i;
    for (int i = 0; i < DIGIT; i++) begin
      d_d[i] = a_d[i] ^ b_d[i] ^ brw;
      brw    = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & brw);
    end
    borrow_o = brw;
  end

endmodule

// File: rtl/subtractor_16bit_seq.sv
// subtractor_16bit_seq
// Multi-cycle subtractor computing diff = a - b - bin, one DIGIT-bit slice per
// cycle, with valid/ready handshakes on both sides.
// Optional feature macro: SUB_ZERO_FLAG_EN adds the registered 'zero' output.
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   in_valid  in   1      operands valid
//   in_ready  out  1      block can accept operands (IDLE)
//   a         in   WIDTH  minuend
//   b         in   WIDTH  subtrahend
//   bin       in   1      borrow-in
//   out_valid out  1      result valid (DONE)
//   out_ready in   1      downstream accepts result
//   diff      out  WIDTH  a - b - bin modulo 2^WIDTH
//   bout      out  1      borrow-out
//   overflow  out  1      signed overflow
//   busy      out  1      state != IDLE
//   zero      out  1      diff == 0 (only with SUB_ZERO_FLAG_EN)
module subtractor_16bit_seq
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             busy
`ifdef SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               borrow;
  logic [WIDTH-1:0]   diff_sr;
  logic [WIDTH-1:0]   diff_next;
  logic [DIGIT-1:0]   slice_d;
  logic               slice_borrow;
  logic               last_digit;

  // One shared slice, fed the digit selected by the counter.
  subtractor_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d      (op_a[cnt*DIGIT +: DIGIT]),
    .b_d      (op_b[cnt*DIGIT +: DIGIT]),
    .borrow_i (borrow),
    .d_d      (slice_d),
    .borrow_o (slice_borrow)
  );

  // Digits enter at the top and shift down, so after NDIG steps digit 0
  // sits in the least significant position.
  assign diff_next  = (diff_sr >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));
  assign last_digit = (cnt == LAST_CNT);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last_digit) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result outputs are written only on the CALC->DONE edge so they hold
  // their previous values through IDLE and the next calculation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      borrow   <= 1'b0;
      diff_sr  <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= a;
            op_b   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        CALC: begin
          diff_sr <= diff_next;
          borrow  <= slice_borrow;
          cnt     <= cnt + CNT_W'(1);
          if (last_digit) begin
            diff     <= diff_next;
            bout     <= slice_borrow;
            overflow <= calc_overflow(op_a[WIDTH-1], op_b[WIDTH-1], diff_next[WIDTH-1]);
`ifdef SUB_ZERO_FLAG_EN
            zero     <= (diff_next == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_16bit_seq.sv
// tb_subtractor_16bit_seq
// Directed-vector bench for subtractor_16bit_seq. Expected results are
// hand-computed constants. Define SUB_ZERO_FLAG_EN to also check 'zero'.
module tb_subtractor_16bit_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        overflow;
  logic        busy;
`ifdef SUB_ZERO_FLAG_EN
  logic        zero;
`endif

  int check_count = 0;
  int error_count = 0;

  subtractor_16bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow),
    .busy      (busy)
`ifdef SUB_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, verify latency and results, optionally hold
  // backpressure in DONE, then drain and verify the held outputs.
  task automatic applyStimulus(input string tag, input logic [15:0] va,
                               input logic [15:0] vb, input logic vbin,
                               input logic [15:0] exp_diff, input logic exp_bout,
                               input logic exp_ovf, input int hold_cycles);
    int cycles;
    in_valid = 1'b1;
    a   = va;
    b   = vb;
    bin = vbin;
    tick();
    in_valid = 1'b0;
    a   = ~va;
    b   = ~vb;
    bin = ~vbin;
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " in_ready calc"}, 32'(in_ready), 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'd4);
    checkOutput({tag, " diff"}, 32'(diff), 32'(exp_diff));
    checkOutput({tag, " bout"}, 32'(bout), 32'(exp_bout));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef SUB_ZERO_FLAG_EN
    checkOutput({tag, " zero"}, 32'(zero), 32'(exp_diff == 16'h0000));
`endif
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = 1'b1;
      a = 16'h0F0F;
      b = 16'h0101;
      tick();
      checkOutput({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, " hold diff"}, 32'(diff), 32'(exp_diff));
      checkOutput({tag, " hold bout"}, 32'(bout), 32'(exp_bout));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " drain in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " drain out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " held diff"}, 32'(diff), 32'(exp_diff));
    checkOutput({tag, " held overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    int cycles;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    bin       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset diff", 32'(diff), 32'd0);
    checkOutput("reset bout", 32'(bout), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
`ifdef SUB_ZERO_FLAG_EN
    checkOutput("reset zero", 32'(zero), 32'd0);
`endif

    applyStimulus("5-3",         16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
    applyStimulus("0-1",         16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
    applyStimulus("8000-1",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
    applyStimulus("7FFF-FFFF",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
    applyStimulus("1234-1234b1", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    applyStimulus("1234-1234b0", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    applyStimulus("A5A5-5A5A bp", 16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 3);

    // Reset on the second CALC cycle discards the partial result.
    in_valid = 1'b1;
    a   = 16'hAAAA;
    b   = 16'h5555;
    bin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort diff", 32'(diff), 32'd0);
    checkOutput("abort bout", 32'(bout), 32'd0);
    checkOutput("abort overflow", 32'(overflow), 32'd0);
    cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) cycles++;
    end
    checkOutput("abort no result", 32'(cycles), 32'd0);

    applyStimulus("10-1 after rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
